// File: rtl/beta_anneal_scheduler.sv
// beta_anneal_scheduler: ramps beta from beta_start to beta_max, one step every N completed sweeps.
// Define BETA_ANNEAL_GEOMETRIC_EN to add beta>>>3 to each increment (quasi-geometric schedule).
`ifndef BETA
`define BETA 16
`endif
module beta_anneal_scheduler #(
    parameter int SWEEP_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic signed [`BETA-1:0]       beta_start,
    input  logic signed [`BETA-1:0]       beta_step,
    input  logic signed [`BETA-1:0]       beta_max,
    input  logic        [SWEEP_CNT_W-1:0] sweeps_per_step,
    input  logic                          sweep_done,
    output logic signed [`BETA-1:0]       beta,
    output logic                          step_strobe,
    output logic                          busy,
    output logic                          done
);
    localparam int BW = `BETA;
`ifdef BETA_ANNEAL_GEOMETRIC_EN
    localparam int SW = BW + 2;
`else
    localparam int SW = BW + 1;
`endif
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t                   r_state, w_state_nxt;
    logic signed [BW-1:0]     r_beta, r_step, r_max;
    logic signed [BW-1:0]     w_beta_nxt, w_step_nxt, w_max_nxt, w_beta_load, w_beta_inc;
    logic [SWEEP_CNT_W-1:0]   r_sweeps, r_cnt, w_sweeps_nxt, w_cnt_nxt, w_eff;
    logic [SWEEP_CNT_W:0]     w_cnt_inc;
    logic                     r_strobe, w_strobe_nxt, w_load, w_last;
    logic signed [SW-1:0]     w_b_x, w_s_x, w_m_x, w_sum;

    assign w_beta_load = (beta_start > beta_max) ? beta_max : beta_start;
    // Widened sum so the increment can never wrap before clamping.
    assign w_b_x = {{(SW-BW){r_beta[BW-1]}}, r_beta};
    assign w_s_x = {{(SW-BW){r_step[BW-1]}}, r_step};
    assign w_m_x = {{(SW-BW){r_max[BW-1]}}, r_max};
`ifdef BETA_ANNEAL_GEOMETRIC_EN
    logic signed [SW-1:0] w_g_x;
    assign w_g_x = {{(SW-BW+3){r_beta[BW-1]}}, r_beta[BW-1:3]};
    assign w_sum = w_b_x + w_s_x + w_g_x;
`else
    assign w_sum = w_b_x + w_s_x;
`endif
    assign w_beta_inc = (w_sum > w_m_x) ? r_max : w_sum[BW-1:0];
    assign w_eff      = (r_sweeps == '0) ? SWEEP_CNT_W'(1) : r_sweeps;
    assign w_cnt_inc  = {1'b0, r_cnt} + (SWEEP_CNT_W+1)'(1);
    assign w_last     = (w_cnt_inc == {1'b0, w_eff});

    always_comb begin
        w_state_nxt  = r_state;
        w_beta_nxt   = r_beta;
        w_step_nxt   = r_step;
        w_max_nxt    = r_max;
        w_sweeps_nxt = r_sweeps;
        w_cnt_nxt    = r_cnt;
        w_strobe_nxt = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: w_load = start && !abort;
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (sweep_done) begin
                    if (!w_last) begin
                        w_cnt_nxt = w_cnt_inc[SWEEP_CNT_W-1:0];
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_beta == r_max) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_beta_nxt   = w_beta_inc;
                            w_strobe_nxt = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_load = start;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_state_nxt  = S_RUN;
            w_beta_nxt   = w_beta_load;
            w_step_nxt   = beta_step;
            w_max_nxt    = beta_max;
            w_sweeps_nxt = sweeps_per_step;
            w_cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_beta   <= '0;
            r_step   <= '0;
            r_max    <= '0;
            r_sweeps <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_beta   <= w_beta_nxt;
            r_step   <= w_step_nxt;
            r_max    <= w_max_nxt;
            r_sweeps <= w_sweeps_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign beta        = r_beta;
    assign step_strobe = r_strobe;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
endmodule
